// File: rtl/uart_tx_port.sv
// -----------------------------------------------------------------------------
// uart_tx_port
// Memory-mapped 8N1 UART transmitter for the CPU I/O window. CPU byte writes
// are queued in a small FIFO. A shifter drains the FIFO LSB first.
//
// Register map (offset from BASE_ADDR):
//   0 DATA   (W)   push din into the FIFO (dropped and overflow set if full)
//   1 STATUS (R)   {4'b0, overflow, busy, empty, full}; a read clears overflow
//   2 COUNT  (R)   FIFO occupancy, zero-extended
//   3 CTRL   (R/W) bit0 tx_enable, bit1 flush (self-clearing),
//                  bit2 parity_enable (only with UART_TX_PORT_PARITY_EN)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   din      CPU write data
//   address  CPU bus address
//   w_en     write strobe (already window-qualified)
//   r_en     read strobe (already window-qualified)
//   dout     registered read data, valid the cycle after the read
//   tx       serial output, idle high
//   irq      level interrupt: FIFO empty and shifter idle (registered)
//
// Optional feature macro: UART_TX_PORT_PARITY_EN
//   Defined   -> an even-parity bit is sent between the last data bit and
//                the stop bit while CTRL.parity_enable is 1.
//   Undefined -> strict 8N1; CTRL bit2 reads 0 and ignores writes.
// -----------------------------------------------------------------------------
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDR    = 16'h1010,
    parameter int          CLKS_PER_BIT = 1250,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic [15:0] address,
    input  logic        w_en,
    input  logic        r_en,
    output logic [7:0]  dout,
    output logic        tx,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [PTR_W:0]   PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] BAUD_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity bit: makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [15:0] offset_s;
    logic        addr_ok_s;
    logic        push_req_s;
    logic        flush_s;
    logic        ctrl_wr_s;
    logic        status_rd_s;

    // An address below BASE_ADDR wraps to a large offset and is rejected.
    assign offset_s    = address - BASE_ADDR;
    assign addr_ok_s   = (offset_s < 16'd4);
    assign push_req_s  = w_en && addr_ok_s && (offset_s[1:0] == 2'd0);
    assign ctrl_wr_s   = w_en && addr_ok_s && (offset_s[1:0] == 2'd3);
    assign flush_s     = ctrl_wr_s && din[1];
    assign status_rd_s = r_en && addr_ok_s && (offset_s[1:0] == 2'd1);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;
    logic [PTR_W:0] count_s;
    logic         full_s;
    logic         empty_s;
    logic         pop_s;
    logic         push_ok_s;
    logic [7:0]   fifo_rdata_s;

    tx_state_e    state_r;
    tx_state_e    state_nxt_s;
    logic         tx_en_r;
    logic         overflow_r;
    logic         parity_en_s;

    assign count_s      = wr_ptr_r - rd_ptr_r;
    assign empty_s      = (wr_ptr_r == rd_ptr_r);
    assign full_s       = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                          (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign fifo_rdata_s = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign pop_s        = (state_r == ST_IDLE) && tx_en_r && !empty_s;
    // A simultaneous pop frees a slot, so a push into a full FIFO is accepted.
    assign push_ok_s    = push_req_s && (!full_s || pop_s);

    // FIFO storage and pointers; flush discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (flush_s) begin
            rd_ptr_r <= wr_ptr_r;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
`ifdef UART_TX_PORT_PARITY_EN
    logic parity_en_r;

    // Parity enable bit of CTRL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_en_r <= 1'b1;
        end else if (ctrl_wr_s) begin
            parity_en_r <= din[2];
        end else begin
            parity_en_r <= parity_en_r;
        end
    end

    assign parity_en_s = parity_en_r;
`else
    assign parity_en_s = 1'b0;
`endif

    // tx_enable bit of CTRL and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                tx_en_r <= din[0];
            end else begin
                tx_en_r <= tx_en_r;
            end
            // A dropped byte wins over a same-edge STATUS read clear.
            if (push_req_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end else if (status_rd_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Registered read data; holds when there is no valid read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else if (r_en && addr_ok_s) begin
            case (offset_s[1:0])
                2'd0:    dout <= 8'h00;
                2'd1:    dout <= {4'b0000, overflow_r, (state_r != ST_IDLE), empty_s, full_s};
                2'd2:    dout <= {{(7 - PTR_W){1'b0}}, count_s};
                2'd3:    dout <= {5'b00000, parity_en_s, 1'b0, tx_en_r};
                default: dout <= 8'h00;
            endcase
        end else begin
            dout <= dout;
        end
    end

    // ------------------------------------------------------------------
    // Shifter FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] baud_r;
    logic [CNT_W-1:0] baud_nxt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nxt_s;
    logic [7:0]       shift_r;
    logic             tx_nxt_s;
    logic             baud_last_s;
    logic             par_r;

    assign baud_last_s = (baud_r == BAUD_MAX);

    // FSM state, counters and registered serial/irq outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            tx        <= 1'b1;
            irq       <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            tx        <= tx_nxt_s;
            irq       <= empty_s && (state_r == ST_IDLE);
        end
    end

    // Frame byte and its parity are captured on the pop edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 8'h00;
            par_r   <= 1'b0;
        end else if (pop_s) begin
            shift_r <= fifo_rdata_s;
            par_r   <= even_parity(fifo_rdata_s);
        end else begin
            shift_r <= shift_r;
            par_r   <= par_r;
        end
    end

    // Next state, baud/bit counters and the line level for the current state.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r;
        bit_idx_nxt_s = bit_idx_r;
        tx_nxt_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                tx_nxt_s = 1'b1;
                if (pop_s) begin
                    state_nxt_s = ST_START;
                    baud_nxt_s  = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_nxt_s = 1'b0;
                if (baud_last_s) begin
                    state_nxt_s   = ST_DATA;
                    baud_nxt_s    = '0;
                    bit_idx_nxt_s = 3'd0;
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                tx_nxt_s = shift_r[bit_idx_r];
                if (baud_last_s) begin
                    baud_nxt_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_nxt_s = 3'd0;
                        if (parity_en_s) begin
                            state_nxt_s = ST_PARITY;
                        end else begin
                            state_nxt_s = ST_STOP;
                        end
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
`ifdef UART_TX_PORT_PARITY_EN
            ST_PARITY: begin
                tx_nxt_s = par_r;
                if (baud_last_s) begin
                    state_nxt_s = ST_STOP;
                    baud_nxt_s  = '0;
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
`endif
            ST_STOP: begin
                tx_nxt_s = 1'b1;
                if (baud_last_s) begin
                    state_nxt_s = ST_IDLE;
                    baud_nxt_s  = '0;
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                baud_nxt_s    = '0;
                bit_idx_nxt_s = 3'd0;
                tx_nxt_s      = 1'b1;
            end
        endcase
    end

`ifndef UART_TX_PORT_PARITY_EN
    // Parity bit is only consumed when the parity feature is built in.
    logic unused_par_s;
    assign unused_par_s = par_r;
`endif

endmodule

// File: tb/tb_uart_tx_port.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_port
// Scoreboard bench for uart_tx_port (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Stimulus pushes expected register reads and expected serial bytes into
// queues; independent monitors pop and compare register reads and decoded
// serial frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_port;

    localparam logic [15:0] BASE  = 16'h1010;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] address = 16'h0000;
    logic        w_en = 1'b0;
    logic        r_en = 1'b0;
    logic [7:0]  dout;
    logic        tx;
    logic        irq;

    uart_tx_port #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .address(address),
        .w_en   (w_en),
        .r_en   (r_en),
        .dout   (dout),
        .tx     (tx),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_frames[$];   // bytes expected on the serial line, in order
    logic [7:0] rd_q[$];         // expected dout values for valid reads

    // Reference model of the register-visible state
    int m_cnt    = 0;
    bit m_ovf    = 1'b0;
    bit m_par_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit par_active();
`ifdef UART_TX_PORT_PARITY_EN
        return m_par_en;
`else
        return 1'b0;
`endif
    endfunction

    // All bus tasks start on a falling edge and return on the next one.
    task automatic wr_raw(input logic [15:0] a, input logic [7:0] d);
        address = a; din = d; w_en = 1'b1;
        @(negedge clk);
        w_en = 1'b0; address = 16'h0000;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        wr_raw(BASE + {14'd0, off}, d);
    endtask

    task automatic rd(input logic [1:0] off, input logic [7:0] e);
        rd_q.push_back(e);
        address = BASE + {14'd0, off}; r_en = 1'b1;
        @(negedge clk);
        r_en = 1'b0; address = 16'h0000;
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
`ifdef UART_TX_PORT_PARITY_EN
        m_par_en = d[2];
`endif
        wr(2'd3, d);
    endtask

    // DATA write while the shifter is stopped: the model decides acceptance.
    task automatic data_wr(input logic [7:0] d);
        if (m_cnt < DEPTH) begin
            m_cnt++;
            exp_frames.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
        wr(2'd0, d);
    endtask

    task automatic rd_status(input bit busy);
        logic [7:0] e;
        e = {4'b0000, m_ovf, busy, (m_cnt == 0), (m_cnt == DEPTH)};
        m_ovf = 1'b0;
        rd(2'd1, e);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        repeat (3) @(negedge clk);
        i = 0;
        while (i < budget && irq !== 1'b1) begin
            @(negedge clk);
            i++;
        end
        check("drain_irq", irq, 1);
        m_cnt = 0;
    endtask

    // Register-read monitor: a valid read strobe at a rising edge means dout
    // carries the next expected value by the following falling edge.
    initial begin
        bit p;
        forever begin
            @(posedge clk);
            p = r_en && (address >= BASE) && (address <= BASE + 16'd3);
            @(negedge clk);
            if (p) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got 0x%0h expected none", dout);
                end else begin
                    check("dout", dout, rd_q.pop_front());
                end
            end
        end
    end

    // Serial monitor: find a start bit, sample each bit mid-way, compare.
    initial begin
        logic [10:0] smp;
        bit ab;
        bit pa;
        int last;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                pa   = par_active();
                last = pa ? (10 * CPB + 2) : (9 * CPB + 2);
                ab   = 1'b0;
                smp  = '0;
                for (int n = 1; n <= last && !ab; n++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    if (n % CPB == 2) smp[n / CPB] = tx;
                end
                if (!ab) begin
                    check("start_bit", smp[0], 0);
                    if (exp_frames.size() == 0) begin
                        total++; bad++;
                        $display("FAIL frame_unexpected: got 0x%02h expected none", smp[8:1]);
                    end else begin
                        check("frame_byte", smp[8:1], exp_frames.pop_front());
                    end
                    if (pa) check("parity_bit", smp[9], ^smp[8:1]);
                    check("stop_bit", smp[last / CPB], 1);
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    logic [7:0] ctrl_rst;
    logic [7:0] b;
    logic [7:0] pbit;
    int n;

    initial begin
`ifdef UART_TX_PORT_PARITY_EN
        ctrl_rst = 8'h05;
`else
        ctrl_rst = 8'h01;
`endif
        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_irq", irq, 1);
        check("rst_dout", dout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rd_status(1'b0);          // 0x02
        rd(2'd2, 8'h00);
        rd(2'd3, ctrl_rst);
        rd(2'd0, 8'h00);          // DATA reads as 0

        // ---- 0xA5 frame timing, cycle by cycle ----
        ctrl_wr(8'h01);
        exp_frames.push_back(8'hA5);
        wr(2'd0, 8'hA5);          // sampled at edge E0
        b = 8'hA5;
        for (int k = 1; k <= 42; k++) begin
            logic et;
            @(posedge clk);
            #1;
            if (k < 2)       et = 1'b1;
            else if (k < 6)  et = 1'b0;
            else if (k < 38) et = b[(k - 6) / 4];
            else             et = 1'b1;
            check($sformatf("a5_tx_k%0d", k), tx, et);
            check($sformatf("a5_irq_k%0d", k), irq, (k == 42) ? 1 : 0);
        end
        @(negedge clk);
        wait_idle(200);

        // ---- 3 queued bytes, shifter stopped, back-to-back reads ----
        ctrl_wr(8'h00);
        rd(2'd3, 8'h00);
        for (int i = 0; i < 3; i++) data_wr(8'($urandom_range(0, 255)));
        wr_raw(BASE + 16'd4, 8'h55);   // outside the map: ignored
        wr_raw(BASE - 16'd1, 8'h55);   // outside the map: ignored
        rd_status(1'b0);               // 0x00
        rd(2'd2, 8'h03);
        address = BASE + 16'd4; r_en = 1'b1;   // invalid read: dout holds
        @(negedge clk);
        r_en = 1'b0; address = 16'h0000;
        check("dout_hold", dout, 8'h03);

        // ---- fill past full: overflow ----
        for (int i = 0; i < 6; i++) data_wr(8'($urandom_range(0, 255)));
        rd_status(1'b0);               // 0x09
        rd(2'd2, 8'h08);
        rd_status(1'b0);               // 0x01

        // ---- full FIFO: pop and push on the same edge ----
        ctrl_wr(8'h01);
        b = 8'($urandom_range(0, 255));
        exp_frames.push_back(b);
        wr(2'd0, b);
        rd(2'd1, 8'h05);               // full, busy, no overflow
        rd(2'd2, 8'h08);
        wait_idle(12 * CPB * 10 + 100);
        rd_status(1'b0);               // 0x02
        rd(2'd2, 8'h00);

        // ---- reset in the middle of a frame ----
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_frames.push_back(b);
            wr(2'd0, b);
        end
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_irq", irq, 1);
        check("midrst_dout", dout, 0);
        exp_frames.delete();
        m_cnt = 0; m_ovf = 1'b0; m_par_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(2'd2, 8'h00);
        rd_status(1'b0);
        rd(2'd3, ctrl_rst);
        repeat (200) @(negedge clk);   // any frame now is unexpected

`ifdef UART_TX_PORT_PARITY_EN
        // ---- parity frames: 11 and 10 bit-times ----
        ctrl_wr(8'h05);
        exp_frames.push_back(8'h07); wr(2'd0, 8'h07);
        exp_frames.push_back(8'h06); wr(2'd0, 8'h06);
        wait_idle(12 * CPB * 3 + 100);
        ctrl_wr(8'h01);
        exp_frames.push_back(8'h07); wr(2'd0, 8'h07);
        exp_frames.push_back(8'h06); wr(2'd0, 8'h06);
        wait_idle(12 * CPB * 3 + 100);
`endif

        // ---- randomized rounds ----
        for (int r = 0; r < 8; r++) begin
            pbit = 8'h00;
`ifdef UART_TX_PORT_PARITY_EN
            pbit = ($urandom_range(0, 1) == 1) ? 8'h04 : 8'h00;
`endif
            ctrl_wr(pbit);
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) data_wr(8'($urandom_range(0, 255)));
            rd_status(1'b0);
            rd(2'd2, 8'(m_cnt));
            rd_status(1'b0);
            if ($urandom_range(0, 3) == 0) begin
                ctrl_wr(8'h02 | pbit);   // flush, shifter still stopped
                while (m_cnt > 0) begin
                    void'(exp_frames.pop_back());
                    m_cnt--;
                end
                rd(2'd2, 8'h00);
            end
            ctrl_wr(8'h01 | pbit);
            wait_idle(m_cnt * 12 * CPB + 100);
            rd_status(1'b0);
        end

        repeat (10) @(negedge clk);
        check("frames_left", exp_frames.size(), 0);
        check("reads_left", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
